mul_hilo_capture: RTL and testbench
===================================

Name: mul_hilo_capture

Overview:
- Sequential stage directly downstream of the combinational 32x32 Booth multiplier.
- Registers the operands that drive the multiplier and waits a fixed number of cycles for the product to settle (multicycle path).
- Captures the 64-bit product into the architectural HI/LO register pair and signals completion to the control unit.
- Also serves the direct HI/LO writes (mthi/mtlo) and continuously drives HI/LO to the datapath (mfhi/mflo).

Parameters:
- SETTLE_CYCLES, 2, number of cycles the multiplier inputs are held stable before the product is sampled; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a multiply; sampled only in IDLE.
- op_a  in  32  multiplicand from the datapath.
- op_b  in  32  multiplier from the datapath.
- mul_a  out  32  registered multiplicand to the multiplier.
- mul_b  out  32  registered multiplier to the multiplier.
- product  in  64  combinational product returned by the multiplier.
- hi_wr  in  1  direct write of wr_data into HI (mthi).
- lo_wr  in  1  direct write of wr_data into LO (mtlo).
- wr_data  in  32  data for direct HI/LO writes.
- busy  out  1  high while a multiply is in flight.
- done  out  1  one-cycle pulse when HI/LO have just been loaded from product.
- hi  out  32  HI register contents.
- lo  out  32  LO register contents.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, mul_a=mul_b=0, count=0, hi=lo=0, busy=0, done=0. A clear in the middle of a multiply aborts it; no HI/LO capture and no done pulse.
- States: IDLE, WAIT.
- IDLE:
  - On a clock edge with start=1: mul_a<=op_a, mul_b<=op_b, count<=SETTLE_CYCLES-1, state<=WAIT.
  - busy=0 in IDLE.
- WAIT:
  - busy=1, combinationally decoded from state.
  - On each edge with count!=0: count<=count-1.
  - On the edge with count==0: hi<=product[63:32], lo<=product[31:0], done<=1, state<=IDLE.
- Timing:
  - If start is sampled at edge E0, busy is high for exactly SETTLE_CYCLES cycles.
  - New HI/LO values and done=1 appear after edge E0+SETTLE_CYCLES.
  - done is a registered pulse and is deasserted on the following edge.
- mul_a/mul_b hold their value from capture until the next accepted start. They are never changed while in WAIT.
- start while busy=1 is ignored; it is neither queued nor reported as an error.
- Back-to-back operation: start asserted in the same cycle that done=1 is accepted, because the state is already IDLE.
- Direct writes:
  - hi_wr/lo_wr are honoured only in IDLE; while busy they are ignored.
  - hi_wr and lo_wr together write wr_data into both HI and LO.
  - start together with hi_wr/lo_wr in IDLE: the direct write takes effect at that edge and the multiply proceeds. The later capture overwrites both HI and LO.
- Arithmetic: signed two's-complement semantics are those of the multiplier. This block performs no arithmetic and passes the product through bit-exact.

Optional Feature:
- Macro HILO_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit), reset to 0.
  - At each capture: ovf <= (product[63:32] != {32{product[31]}}), i.e. the product does not fit in 32 signed bits.
  - Cleared by a direct HI/LO write.
  - Holds its value otherwise.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with op_a=7, op_b=0xFFFFFFFD (-3), SETTLE_CYCLES=2 -> busy high for 2 cycles; done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000; with HILO_OVF_FLAG_EN, ovf=1. A following 7*-3 multiply gives ovf=0.
- Second start asserted during WAIT with op_a=5 -> ignored: mul_a does not change, the first result is captured, and only one done pulse occurs.
- In IDLE: hi_wr=1, wr_data=0x12345678 -> hi=0x12345678, lo unchanged. Repeat during busy -> no change. Assert start and lo_wr together -> lo=wr_data for the settle window, then the product overwrites it.
- Assert clear asynchronously in the middle of WAIT -> busy, done, hi and lo go to 0 immediately; no done pulse follows; the next start completes normally.
- Assert start in the cycle done=1 with operands 3 and 4 -> accepted; hi=0, lo=12 after SETTLE_CYCLES more cycles. Repeat with SETTLE_CYCLES=1 to confirm single-cycle busy.

Source files
------------

// File: rtl/mul_hilo_capture.sv
// HI/LO capture stage for the multicycle 32x32 multiplier.
// Registers the multiplier operands, waits SETTLE_CYCLES (legal range 1..15) for the
// combinational product to settle, then loads it into HI/LO and pulses done. It also
// serves direct HI/LO writes (mthi/mtlo) while idle.
// Optional build macro HILO_OVF_FLAG_EN adds o_ovf, which is set at capture when the
// product does not fit in 32 signed bits.
module mul_hilo_capture #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [63:0] i_product,
  input  logic        i_hi_wr,
  input  logic        i_lo_wr,
  input  logic [31:0] i_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
`ifdef HILO_OVF_FLAG_EN
  ,
  output logic        o_ovf
`endif
);

  // Counter is loaded with SETTLE_CYCLES-1 so capture happens on the SETTLE_CYCLES-th edge.
  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic [31:0] r_mul_a, w_mul_a_nxt;
  logic [31:0] r_mul_b, w_mul_b_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic        r_done, w_done_nxt;
`ifdef HILO_OVF_FLAG_EN
  logic        r_ovf, w_ovf_nxt;
`endif

  // Next-state decode: operand capture, settle countdown, HI/LO capture and direct writes.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_mul_a_nxt = r_mul_a;
    w_mul_b_nxt = r_mul_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
`ifdef HILO_OVF_FLAG_EN
    w_ovf_nxt   = r_ovf;
`endif
    unique case (r_state)
      StIdle: begin
        // Direct writes land even when a multiply starts on the same edge; the later
        // capture overwrites both halves anyway.
        if (i_hi_wr) w_hi_nxt = i_wr_data;
        if (i_lo_wr) w_lo_nxt = i_wr_data;
`ifdef HILO_OVF_FLAG_EN
        if (i_hi_wr || i_lo_wr) w_ovf_nxt = 1'b0;
`endif
        if (i_start) begin
          w_mul_a_nxt = i_op_a;
          w_mul_b_nxt = i_op_b;
          w_count_nxt = SettleInit;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        // start, hi_wr and lo_wr are deliberately ignored here.
        if (r_count != 4'd0) begin
          w_count_nxt = r_count - 4'd1;
        end else begin
          w_hi_nxt    = i_product[63:32];
          w_lo_nxt    = i_product[31:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
`ifdef HILO_OVF_FLAG_EN
          w_ovf_nxt   = (i_product[63:32] != {32{i_product[31]}});
`endif
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers; clear aborts any in-flight multiply.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state <= StIdle;
      r_count <= 4'd0;
      r_mul_a <= 32'd0;
      r_mul_b <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
`ifdef HILO_OVF_FLAG_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_mul_a <= w_mul_a_nxt;
      r_mul_b <= w_mul_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
`ifdef HILO_OVF_FLAG_EN
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  assign o_mul_a = r_mul_a;
  assign o_mul_b = r_mul_b;
  assign o_busy  = (r_state == StWait);
  assign o_done  = r_done;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
`ifdef HILO_OVF_FLAG_EN
  assign o_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_mul_hilo_capture.sv
// Bench for mul_hilo_capture: scoreboard of expected HI/LO values, popped on each done pulse.
// A second instance with SETTLE_CYCLES=1 covers the single-cycle busy case.
module tb_mul_hilo_capture;

  logic        clk;
  logic        i_clear;
  logic        i_start, i_hi_wr, i_lo_wr;
  logic [31:0] i_op_a, i_op_b, i_wr_data;
  logic [31:0] o_mul_a, o_mul_b, o_hi, o_lo;
  logic [63:0] w_product;
  logic        o_busy, o_done;

  logic        s1_start;
  logic [31:0] s1_op_a, s1_op_b, s1_mul_a, s1_mul_b, s1_hi, s1_lo;
  logic [63:0] s1_product;
  logic        s1_busy, s1_done;
`ifdef HILO_OVF_FLAG_EN
  logic        o_ovf, s1_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } exp_t;
  exp_t sb[$];
  exp_t m_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational signed multiplier.
  assign w_product  = $signed({{32{o_mul_a[31]}}, o_mul_a}) * $signed({{32{o_mul_b[31]}}, o_mul_b});
  assign s1_product = $signed({{32{s1_mul_a[31]}}, s1_mul_a}) *
                      $signed({{32{s1_mul_b[31]}}, s1_mul_b});

  mul_hilo_capture #(.SETTLE_CYCLES(2)) u_dut (
    .i_clock   (clk),
    .i_clear   (i_clear),
    .i_start   (i_start),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .o_mul_a   (o_mul_a),
    .o_mul_b   (o_mul_b),
    .i_product (w_product),
    .i_hi_wr   (i_hi_wr),
    .i_lo_wr   (i_lo_wr),
    .i_wr_data (i_wr_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
`ifdef HILO_OVF_FLAG_EN
    ,
    .o_ovf     (o_ovf)
`endif
  );

  mul_hilo_capture #(.SETTLE_CYCLES(1)) u_dut1 (
    .i_clock   (clk),
    .i_clear   (i_clear),
    .i_start   (s1_start),
    .i_op_a    (s1_op_a),
    .i_op_b    (s1_op_b),
    .o_mul_a   (s1_mul_a),
    .o_mul_b   (s1_mul_b),
    .i_product (s1_product),
    .i_hi_wr   (1'b0),
    .i_lo_wr   (1'b0),
    .i_wr_data (32'd0),
    .o_busy    (s1_busy),
    .o_done    (s1_done),
    .o_hi      (s1_hi),
    .o_lo      (s1_lo)
`ifdef HILO_OVF_FLAG_EN
    ,
    .o_ovf     (s1_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    exp_t e;
    p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.ovf = (p[63:32] != {32{p[31]}});
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an accepted start and record its expected result.
  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op_a  = a;
    i_op_b  = b;
    sb.push_back(model(a, b));
    step();
    i_start = 1'b0;
  endtask

  // Count busy cycles until done; returns at the negedge where done is seen.
  task automatic wait_done(input int exp_busy);
    int  busy_cnt = 0;
    bit  seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) busy_cnt++;
    end
    if (!seen) check_eq("done_timeout", 64'(o_done), 64'd1);
    else       check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(o_done), 64'd0);
      end else begin
        m_exp = sb.pop_front();
        check_eq("sb_hi", 64'(o_hi), 64'(m_exp.hi));
        check_eq("sb_lo", 64'(o_lo), 64'(m_exp.lo));
`ifdef HILO_OVF_FLAG_EN
        check_eq("sb_ovf", 64'(o_ovf), 64'(m_exp.ovf));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_clear = 1'b1;
    i_start = 1'b0; i_hi_wr = 1'b0; i_lo_wr = 1'b0;
    i_op_a = '0; i_op_b = '0; i_wr_data = '0;
    s1_start = 1'b0; s1_op_a = '0; s1_op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_hi", 64'(o_hi), 64'd0);
    check_eq("rst_lo", 64'(o_lo), 64'd0);
    check_eq("rst_mul", {o_mul_a, o_mul_b}, 64'd0);
`ifdef HILO_OVF_FLAG_EN
    check_eq("rst_ovf", 64'(o_ovf), 64'd0);
`endif
    i_clear = 1'b0;
    step();

    // 7 * -3
    start_mul(32'd7, 32'hFFFF_FFFD);
    wait_done(2);
    check_eq("t1_hi", 64'(o_hi), 64'hFFFF_FFFF);
    check_eq("t1_lo", 64'(o_lo), 64'hFFFF_FFEB);
    check_eq("t1_mul_a_hold", 64'(o_mul_a), 64'd7);

    // Most negative squared, then a small product clears ovf, then overflow again.
    step();
    start_mul(32'h8000_0000, 32'h8000_0000);
    wait_done(2);
    check_eq("t2_hi", 64'(o_hi), 64'h4000_0000);
    check_eq("t2_lo", 64'(o_lo), 64'd0);
    start_mul(32'd7, 32'hFFFF_FFFD);
    wait_done(2);
    start_mul(32'h8000_0000, 32'h8000_0000);
    wait_done(2);

    // Direct HI write in idle; LO untouched, ovf cleared.
    step();
    i_hi_wr = 1'b1; i_wr_data = 32'h1234_5678;
    step();
    i_hi_wr = 1'b0;
    check_eq("mthi_hi", 64'(o_hi), 64'h1234_5678);
    check_eq("mthi_lo", 64'(o_lo), 64'd0);
`ifdef HILO_OVF_FLAG_EN
    check_eq("mthi_ovf", 64'(o_ovf), 64'd0);
`endif

    // Direct write while busy is ignored.
    start_mul(32'd9, 32'd10);
    i_hi_wr = 1'b1; i_wr_data = 32'hDEAD_BEEF;
    step();
    i_hi_wr = 1'b0;
    check_eq("busy_mthi", 64'(o_hi), 64'h1234_5678);
    wait_done(1);

    // Start during WAIT is ignored.
    step();
    start_mul(32'd17, 32'd3);
    i_start = 1'b1; i_op_a = 32'd5;
    step();
    i_start = 1'b0;
    check_eq("ign_mul_a", 64'(o_mul_a), 64'd17);
    wait_done(1);
    repeat (4) step();

    // start together with lo_wr: LO shows wr_data until capture.
    i_start = 1'b1; i_op_a = 32'd6; i_op_b = 32'd7;
    i_lo_wr = 1'b1; i_wr_data = 32'hCAFE_F00D;
    sb.push_back(model(32'd6, 32'd7));
    step();
    i_start = 1'b0; i_lo_wr = 1'b0;
    check_eq("stlo_lo", 64'(o_lo), 64'hCAFE_F00D);
    check_eq("stlo_hi", 64'(o_hi), 64'd0);
    wait_done(2);
    check_eq("stlo_final", 64'(o_lo), 64'd42);

    // Asynchronous clear mid-WAIT aborts the multiply.
    step();
    start_mul(32'd100, 32'd200);
    #2 i_clear = 1'b1;
    #1;
    check_eq("clr_busy", 64'(o_busy), 64'd0);
    check_eq("clr_done", 64'(o_done), 64'd0);
    check_eq("clr_hilo", {o_hi, o_lo}, 64'd0);
    void'(sb.pop_back());
    step();
    i_clear = 1'b0;
    repeat (4) step();
    check_eq("clr_idle", 64'(o_busy), 64'd0);
    start_mul(32'd3, 32'd5);
    wait_done(2);

    // Back-to-back: start in the done cycle is accepted.
    start_mul(32'd3, 32'd4);
    check_eq("b2b_busy", 64'(o_busy), 64'd1);
    wait_done(2);
    check_eq("b2b_hilo", {o_hi, o_lo}, 64'd12);

    // SETTLE_CYCLES=1 instance: single busy cycle, then back-to-back.
    step();
    s1_start = 1'b1; s1_op_a = 32'd3; s1_op_b = 32'd4;
    step();
    s1_start = 1'b0;
    check_eq("s1_busy", {s1_busy, s1_done}, 64'b10);
    step();
    check_eq("s1_done", {s1_busy, s1_done}, 64'b01);
    check_eq("s1_hilo", {s1_hi, s1_lo}, 64'd12);
    s1_start = 1'b1; s1_op_a = 32'hFFFF_FFFF; s1_op_b = 32'hFFFF_FFFF;
    step();
    s1_start = 1'b0;
    check_eq("s1_b2b_busy", {s1_busy, s1_done}, 64'b10);
    step();
    check_eq("s1_b2b_done", {s1_busy, s1_done}, 64'b01);
    check_eq("s1_b2b_hilo", {s1_hi, s1_lo}, 64'd1);

    repeat (3) step();
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
